maze_controller_p: RTL and testbench

Parametrised successor of the lab maze controller. It moves a player cursor over a MAZE_COLS x MAZE_ROWS tile map stored in the maze ROM, and checks every move against a bounds test and a wall lookup in the ROM. It adds a configurable arm sequence, a fixed row-major address map, configurable ROM read latency, in-game restart, and move/bump counters. It sits between the debounced button inputs, the maze ROM and the VGA/LED front end.

---
 rtl/maze_pkg.sv | 20 ++
 rtl/maze_edge_det.sv | 23 ++
 rtl/maze_controller_p.sv | 203 ++++++++++++++++++++
 tb/tb_maze_controller_p.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and helpers for the parametrised maze controller.
package maze_pkg;

    typedef enum logic [2:0] {IDLE, PLAY, FETCH, WAIT, CHECK, END} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    // Bit positions of the buttons inside the edge-detector vector
    localparam int EDGE_W      = 5;
    localparam int BTN_CONTROL = 4;
    localparam int BTN_UP      = 3;
    localparam int BTN_DOWN    = 2;
    localparam int BTN_LEFT    = 1;
    localparam int BTN_RIGHT   = 0;

    // A tile is a wall when its RGB444 colour field is black; the low nibble is don't-care.
    function automatic logic is_wall(input logic [15:0] tile);
        return (tile & 16'hFFF0) == 16'h0000;
    endfunction

endpackage

// File: rtl/maze_edge_det.sv
// Rising-edge detector for debounced level buttons; a held level yields one pulse.
module maze_edge_det #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/maze_controller_p.sv
// Maze cursor controller: arm sequence, bounds/wall-checked moves via the maze ROM,
// in-game restart, saturating move/bump counters and an exit detector.
//
// state | meaning
// IDLE  | counting control presses until the game is armed
// PLAY  | waiting for a direction or restart press
// FETCH | one-cycle ROM read strobe for the candidate tile
// WAIT  | remaining ROM latency cycles
// CHECK | ROM data valid; accept or reject the move
// END   | exit reached; everything frozen until a control press
module maze_controller_p
    import maze_pkg::*;
#(
    parameter int MAZE_COLS   = 40,
    parameter int MAZE_ROWS   = 30,
    parameter int COL_W       = 6,
    parameter int ROW_W       = 6,
    parameter int ADDR_W      = 11,
    parameter int ROM_LAT     = 1,
    parameter int START_COL   = 1,
    parameter int START_ROW   = 0,
    parameter int ARM_PRESSES = 3,
    parameter int CNT_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_control,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_left,
    input  logic              i_right,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic [COL_W-1:0]  o_player_bcol,
    output logic [ROW_W-1:0]  o_player_brow,
    input  logic [COL_W-1:0]  i_exit_bcol,
    input  logic [ROW_W-1:0]  i_exit_brow,
    output logic [CNT_W-1:0]  o_moves,
    output logic [CNT_W-1:0]  o_bumps,
    output logic              o_done,
    output logic [7:0]        o_leds
);

    localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(MAZE_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(MAZE_ROWS - 1);
    localparam logic [2:0]       ARM_LAST  = 3'(ARM_PRESSES - 1);
    localparam logic [1:0]       WAIT_LOAD = 2'((ROM_LAT > 1) ? ROM_LAT - 2 : 0);

    logic [EDGE_W-1:0] rise;
    state_t            state;
    logic [2:0]        arm_cnt;
    logic [1:0]        lat_cnt;
    logic [COL_W-1:0]  pos_col, cand_col, next_col;
    logic [ROW_W-1:0]  pos_row, cand_row, next_row;
    logic [CNT_W-1:0]  moves, bumps, moves_inc, bumps_inc;
    logic [ADDR_W-1:0] next_addr;
    dir_t              dir;
    logic              dir_hit;
    logic              off_map;

    maze_edge_det #(.WIDTH(EDGE_W)) u_edge_det (
        .clk   (clk),
        .rst_n (rst),
        .level ({i_control, i_up, i_down, i_left, i_right}),
        .rise  (rise)
    );

    // Direction priority: up > down > left > right; losers of a tie are dropped.
    always_comb begin
        dir_hit = 1'b1;
        dir     = DIR_UP;
        if (rise[BTN_UP])         dir = DIR_UP;
        else if (rise[BTN_DOWN])  dir = DIR_DOWN;
        else if (rise[BTN_LEFT])  dir = DIR_LEFT;
        else if (rise[BTN_RIGHT]) dir = DIR_RIGHT;
        else                      dir_hit = 1'b0;

        next_col = pos_col;
        next_row = pos_row;
        off_map  = 1'b0;
        case (dir)
            DIR_UP:    if (pos_row == '0)      off_map = 1'b1; else next_row = pos_row - ROW_W'(1);
            DIR_DOWN:  if (pos_row == ROW_LAST) off_map = 1'b1; else next_row = pos_row + ROW_W'(1);
            DIR_LEFT:  if (pos_col == '0)      off_map = 1'b1; else next_col = pos_col - COL_W'(1);
            DIR_RIGHT: if (pos_col == COL_LAST) off_map = 1'b1; else next_col = pos_col + COL_W'(1);
            default:   off_map = 1'b1;
        endcase

        next_addr = ADDR_W'(next_row) * ADDR_W'(MAZE_COLS) + ADDR_W'(next_col);
    end

    assign moves_inc = (moves == '1) ? moves : moves + CNT_W'(1);
    assign bumps_inc = (bumps == '1) ? bumps : bumps + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            arm_cnt    <= '0;
            lat_cnt    <= '0;
            pos_col    <= COL_START;
            pos_row    <= ROW_START;
            cand_col   <= '0;
            cand_row   <= '0;
            moves      <= '0;
            bumps      <= '0;
            o_rom_en   <= 1'b0;
            o_rom_addr <= '0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise[BTN_CONTROL]) begin
                        if (arm_cnt == ARM_LAST) begin
                            arm_cnt <= '0;
                            moves   <= '0;
                            bumps   <= '0;
                            state   <= PLAY;
                        end else begin
                            arm_cnt <= arm_cnt + 3'd1;
                        end
                    end
                end
                PLAY: begin
                    if (rise[BTN_CONTROL]) begin
                        pos_col <= COL_START;
                        pos_row <= ROW_START;
                        moves   <= '0;
                        bumps   <= '0;
                    end else if (dir_hit) begin
                        if (off_map) begin
                            bumps <= bumps_inc;
                        end else begin
                            cand_col   <= next_col;
                            cand_row   <= next_row;
                            o_rom_en   <= 1'b1;
                            o_rom_addr <= next_addr;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    o_rom_en   <= 1'b0;
                    o_rom_addr <= '0;
                    lat_cnt    <= WAIT_LOAD;
                    if (ROM_LAT > 1) state <= WAIT;
                    else             state <= CHECK;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) state <= CHECK;
                    else                 lat_cnt <= lat_cnt - 2'd1;
                end
                CHECK: begin
                    if (is_wall(i_rom_data)) begin
                        bumps <= bumps_inc;
                        state <= PLAY;
                    end else begin
                        pos_col <= cand_col;
                        pos_row <= cand_row;
                        moves   <= moves_inc;
                        if (cand_col == i_exit_bcol && cand_row == i_exit_brow) begin
                            o_done <= 1'b1;
                            state  <= END;
                        end else begin
                            state <= PLAY;
                        end
                    end
                end
                END: begin
                    if (rise[BTN_CONTROL]) begin
                        pos_col <= COL_START;
                        pos_row <= ROW_START;
                        arm_cnt <= '0;
                        o_done  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status display: arm progress as a thermometer, move count in play, all-on at the exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_leds <= 8'h00;
        end else begin
            case (state)
                IDLE:    o_leds <= 8'((9'd1 << arm_cnt) - 9'd1);
                END:     o_leds <= 8'hFF;
                default: o_leds <= 8'(moves);
            endcase
        end
    end

    assign o_player_bcol = pos_col;
    assign o_player_brow = pos_row;
    assign o_moves       = moves;
    assign o_bumps       = bumps;

endmodule

// File: tb/tb_maze_controller_p.sv
// Self-checking bench for maze_controller_p with ROM_LAT=1 and ROM_LAT=3 instances in lockstep.
module tb_maze_controller_p;

    localparam logic [4:0] B_CTRL  = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btn = 5'b0;
    logic [5:0]  exit_col = 6'd39;
    logic [5:0]  exit_row = 6'd29;

    logic        rom_en1, rom_en3, done1, done3;
    logic [10:0] rom_addr1, rom_addr3;
    logic [15:0] rom_data1, rom_data3;
    logic [5:0]  pcol1, prow1, pcol3, prow3;
    logic [9:0]  moves1, bumps1, moves3, bumps3;
    logic [7:0]  leds1, leds3;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses1  = 0;
    int pulses3  = 0;

    logic [10:0] addr_q1[$];
    logic [10:0] addr_q3[$];
    logic [31:0] exp_q[$];

    logic [5:0]  m_col   = 6'd1;
    logic [5:0]  m_row   = 6'd0;
    logic [9:0]  m_moves = 10'd0;
    logic [9:0]  m_bumps = 10'd0;

    always #5 clk = ~clk;

    maze_controller_p #(.ROM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .i_control(btn[4]), .i_up(btn[3]), .i_down(btn[2]),
        .i_left(btn[1]), .i_right(btn[0]), .o_rom_en(rom_en1), .o_rom_addr(rom_addr1),
        .i_rom_data(rom_data1), .o_player_bcol(pcol1), .o_player_brow(prow1),
        .i_exit_bcol(exit_col), .i_exit_brow(exit_row), .o_moves(moves1), .o_bumps(bumps1),
        .o_done(done1), .o_leds(leds1)
    );

    maze_controller_p #(.ROM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .i_control(btn[4]), .i_up(btn[3]), .i_down(btn[2]),
        .i_left(btn[1]), .i_right(btn[0]), .o_rom_en(rom_en3), .o_rom_addr(rom_addr3),
        .i_rom_data(rom_data3), .o_player_bcol(pcol3), .o_player_brow(prow3),
        .i_exit_bcol(exit_col), .i_exit_brow(exit_row), .o_moves(moves3), .o_bumps(bumps3),
        .o_done(done3), .o_leds(leds3)
    );

    // ROM models: data is only valid exactly ROM_LAT cycles after the strobe, a wall otherwise.
    function automatic logic [15:0] tile(input logic [10:0] a);
        if (a == 11'd41) return 16'h000F;
        return 16'hFFF0;
    endfunction

    logic        v1 = 1'b0;
    logic [10:0] a1 = '0;
    logic [2:0]  v3 = 3'b0;
    logic [10:0] a3 [3];

    always @(posedge clk) begin
        v1    <= rom_en1;
        a1    <= rom_addr1;
        v3    <= {v3[1:0], rom_en3};
        a3[0] <= rom_addr3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end

    assign rom_data1 = v1    ? tile(a1)    : 16'h0000;
    assign rom_data3 = v3[2] ? tile(a3[2]) : 16'h0000;

    // Scoreboard for ROM reads: every strobe must match the next expected address.
    always @(negedge clk) begin
        if (rst && rom_en1) begin
            pulses1++;
            n_checks++;
            if (addr_q1.size() == 0) begin
                n_fail++;
                $display("FAIL rom_addr_lat1 unexpected strobe addr=%0d", rom_addr1);
            end else if (rom_addr1 !== addr_q1[0]) begin
                n_fail++;
                $display("FAIL rom_addr_lat1 got %0d expected %0d", rom_addr1, addr_q1[0]);
                void'(addr_q1.pop_front());
            end else begin
                void'(addr_q1.pop_front());
            end
        end
        if (rst && rom_en3) begin
            pulses3++;
            n_checks++;
            if (addr_q3.size() == 0) begin
                n_fail++;
                $display("FAIL rom_addr_lat3 unexpected strobe addr=%0d", rom_addr3);
            end else if (rom_addr3 !== addr_q3[0]) begin
                n_fail++;
                $display("FAIL rom_addr_lat3 got %0d expected %0d", rom_addr3, addr_q3[0]);
                void'(addr_q3.pop_front());
            end else begin
                void'(addr_q3.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] sat(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    // Reference model of one PLAY-state event; pushes expected ROM address and result.
    task automatic model_move(input logic [4:0] b);
        logic [5:0]  c;
        logic [5:0]  r;
        logic        off;
        logic [10:0] a;
        logic [15:0] t;
        c   = m_col;
        r   = m_row;
        off = 1'b0;
        if (b[4]) begin
            m_col = 6'd1; m_row = 6'd0; m_moves = 10'd0; m_bumps = 10'd0;
        end else begin
            if (b[3])      begin if (r == 6'd0)  off = 1'b1; else r = r - 6'd1; end
            else if (b[2]) begin if (r == 6'd29) off = 1'b1; else r = r + 6'd1; end
            else if (b[1]) begin if (c == 6'd0)  off = 1'b1; else c = c - 6'd1; end
            else if (b[0]) begin if (c == 6'd39) off = 1'b1; else c = c + 6'd1; end
            if (off) begin
                m_bumps = sat(m_bumps);
            end else begin
                a = 11'(int'(r) * 40 + int'(c));
                addr_q1.push_back(a);
                addr_q3.push_back(a);
                t = tile(a);
                if (t[15:4] == 12'h000) m_bumps = sat(m_bumps);
                else begin m_col = c; m_row = r; m_moves = sat(m_moves); end
            end
        end
        exp_q.push_back({m_col, m_row, m_moves, m_bumps});
    endtask

    task automatic press(input logic [4:0] b, input int hold, input int gap);
        @(posedge clk);
        #1 btn = b;
        repeat (hold) tick();
        btn = 5'b0;
        repeat (gap) tick();
    endtask

    task automatic do_move(input logic [4:0] b);
        @(posedge clk);
        #1 btn = b;
        model_move(b);
        tick();
        btn = 5'b0;
        repeat (9) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({rom_en1, rom_addr1, done1, leds1} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1 got en=%b addr=%0d done=%b leds=%h required 0", rom_en1, rom_addr1, done1, leds1);
        end
        n_checks++;
        if ({rom_en3, rom_addr3, done3, leds3} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3 got en=%b addr=%0d done=%b leds=%h required 0", rom_en3, rom_addr3, done3, leds3);
        end
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== {6'd1, 6'd0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL reset_state_lat1 got (%0d,%0d) m=%0d b=%0d required (1,0) 0 0", pcol1, prow1, moves1, bumps1);
        end
        n_checks++;
        if ({pcol3, prow3, moves3, bumps3} !== {6'd1, 6'd0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL reset_state_lat3 got (%0d,%0d) m=%0d b=%0d required (1,0) 0 0", pcol3, prow3, moves3, bumps3);
        end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_arm();
        press(B_CTRL, 1, 4);
        n_checks++;
        if (leds1 !== 8'b0000_0001 || leds3 !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL arm_one_press got %b/%b required 00000001", leds1, leds3);
        end
        press(B_CTRL, 50, 4);
        n_checks++;
        if (leds1 !== 8'b0000_0011 || leds3 !== 8'b0000_0011 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_held_press got %b/%b done=%b required 00000011 done=0", leds1, leds3, done1);
        end
        press(B_CTRL, 1, 4);
        n_checks++;
        if (leds1 !== 8'h00 || leds3 !== 8'h00) begin
            n_fail++;
            $display("FAIL arm_enter_play got %h/%h required 00", leds1, leds3);
        end
    endtask

    task automatic test_legal_move();
        logic [31:0] got;
        logic [11:0] want1;
        logic [11:0] want3;
        @(posedge clk);
        #1 btn = B_RIGHT;
        model_move(B_RIGHT);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                btn = 5'b0;
                n_checks++;
                if (rom_en1 !== 1'b1 || rom_en3 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL legal_strobe_rise cycle=%0d got %b/%b required 1", k, rom_en1, rom_en3);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (rom_en1 !== 1'b0 || rom_en3 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL legal_strobe_fall cycle=%0d got %b/%b required 0", k, rom_en1, rom_en3);
                end
            end
            want1 = (k >= 3) ? {6'd2, 6'd0} : {6'd1, 6'd0};
            want3 = (k >= 5) ? {6'd2, 6'd0} : {6'd1, 6'd0};
            n_checks++;
            if ({pcol1, prow1} !== want1) begin
                n_fail++;
                $display("FAIL legal_timing_lat1 cycle=%0d got (%0d,%0d) required (%0d,%0d)", k, pcol1, prow1, want1[11:6], want1[5:0]);
            end
            n_checks++;
            if ({pcol3, prow3} !== want3) begin
                n_fail++;
                $display("FAIL legal_timing_lat3 cycle=%0d got (%0d,%0d) required (%0d,%0d)", k, pcol3, prow3, want3[11:6], want3[5:0]);
            end
        end
        repeat (3) tick();
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL legal_result got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
        n_checks++;
        if (leds1 !== 8'd1) begin
            n_fail++;
            $display("FAIL legal_leds got %h required 01", leds1);
        end
        do_move(B_LEFT);
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL legal_back got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
    endtask

    task automatic test_restart_wall();
        logic [31:0] got;
        do_move(B_CTRL);
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL restart got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
        do_move(B_DOWN);
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL wall got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] got;
        int p1;
        int p3;
        p1 = pulses1;
        p3 = pulses3;
        do_move(B_UP);
        do_move(B_UP | B_LEFT);
        n_checks++;
        if (pulses1 != p1 || pulses3 != p3) begin
            n_fail++;
            $display("FAIL bounds_no_rom got %0d/%0d strobes required 0", pulses1 - p1, pulses3 - p3);
        end
        void'(exp_q.pop_front());
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL bounds_up_priority got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
        do_move(B_LEFT);
        p1 = pulses1;
        do_move(B_LEFT);
        n_checks++;
        if (pulses1 != p1) begin
            n_fail++;
            $display("FAIL bounds_left_no_rom got %0d strobes required 0", pulses1 - p1);
        end
        do_move(B_RIGHT);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL bounds_left_edge got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
    endtask

    task automatic test_saturation();
        do_move(B_CTRL);
        void'(exp_q.pop_front());
        for (int i = 0; i < 1030; i++) begin
            @(posedge clk);
            #1 btn = B_UP;
            tick();
            btn = 5'b0;
        end
        repeat (3) tick();
        n_checks++;
        if (bumps1 !== 10'h3FF || bumps3 !== 10'h3FF || moves1 !== 10'd0) begin
            n_fail++;
            $display("FAIL bumps_saturate got %0d/%0d moves=%0d required 1023 moves=0", bumps1, bumps3, moves1);
        end
        do_move(B_CTRL);
        void'(exp_q.pop_front());
    endtask

    task automatic test_exit();
        logic [31:0] got;
        int p1;
        exit_col = 6'd2;
        exit_row = 6'd0;
        do_move(B_RIGHT);
        got = exp_q.pop_front();
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || {pcol3, prow3, moves3, bumps3} !== got) begin
            n_fail++;
            $display("FAIL exit_move got %h/%h required %h", {pcol1, prow1, moves1, bumps1}, {pcol3, prow3, moves3, bumps3}, got);
        end
        n_checks++;
        if (done1 !== 1'b1 || done3 !== 1'b1 || leds1 !== 8'hFF || leds3 !== 8'hFF) begin
            n_fail++;
            $display("FAIL exit_done got done=%b/%b leds=%h/%h required 1 FF", done1, done3, leds1, leds3);
        end
        p1 = pulses1;
        press(B_DOWN, 1, 8);
        n_checks++;
        if ({pcol1, prow1, moves1, bumps1} !== got || pulses1 != p1) begin
            n_fail++;
            $display("FAIL end_frozen got %h strobes=%0d required %h 0", {pcol1, prow1, moves1, bumps1}, pulses1 - p1, got);
        end
        press(B_CTRL, 1, 8);
        n_checks++;
        if ({pcol1, prow1, done1, leds1} !== {6'd1, 6'd0, 1'b0, 8'h00} ||
            {pcol3, prow3, done3, leds3} !== {6'd1, 6'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL end_to_idle got (%0d,%0d) done=%b leds=%h required (1,0) 0 00", pcol1, prow1, done1, leds1);
        end
        exit_col = 6'd39;
        exit_row = 6'd29;
        m_col = 6'd1;
        m_row = 6'd0;
    endtask

    task automatic test_reset_mid();
        repeat (3) press(B_CTRL, 1, 4);
        @(posedge clk);
        #1 btn = B_RIGHT;
        addr_q1.push_back(11'd2);
        addr_q3.push_back(11'd2);
        tick();
        btn = 5'b0;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rom_en3, rom_addr3, done3, leds3} !== 21'd0 || {pcol3, prow3, moves3, bumps3} !== {6'd1, 6'd0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_wait got en=%b addr=%0d (%0d,%0d) m=%0d b=%0d required reset values", rom_en3, rom_addr3, pcol3, prow3, moves3, bumps3);
        end
        tick();
        rst = 1'b1;
        repeat (8) tick();
        n_checks++;
        if ({pcol3, prow3, moves3, bumps3, done3, leds3} !== {6'd1, 6'd0, 10'd0, 10'd0, 1'b0, 8'h00} ||
            {pcol1, prow1, moves1, bumps1} !== {6'd1, 6'd0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_late_data got (%0d,%0d) m=%0d b=%0d leds=%h required (1,0) 0 0 00", pcol3, prow3, moves3, bumps3, leds3);
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_legal_move();
        test_restart_wall();
        test_bounds();
        test_saturation();
        test_exit();
        test_reset_mid();
        n_checks++;
        if (addr_q1.size() != 0 || addr_q3.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d/%0d pending required 0", addr_q1.size(), addr_q3.size(), exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
